// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its line synchronizer.
package ps2_pkg;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQUEST   = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  // Error codes reported on err_code alongside the error pulse.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  // Common keyboard command bytes.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // PS/2 frames carry odd parity: the parity bit makes the count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a
// falling-edge pulse on the synchronized clock. Idle lines read high,
// so the flops reset to 1 to avoid a false edge after reset.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic line_clk_i,
  input  logic line_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic clk_fe_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;

  // Synchronizer chains and previous-level register for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], line_clk_i};
      data_sync_q <= {data_sync_q[0], line_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_s_o  = clk_sync_q[1];
  assign data_s_o = data_sync_q[1];
  assign clk_fe_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a
// request-to-send, shifts out one byte with odd parity on device clock
// falling edges, checks the device ACK and waits for the bus to go idle.
//
// Command handshake: a byte is accepted on a rising clock edge where
// cmd_valid and cmd_ready are both high; cmd_data is sampled only then.
// cmd_ready is high only while idle, so cmd_valid at any other time is
// ignored and the requester must hold cmd_valid until it sees cmd_ready.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       busy,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state_q, state_d;
  logic [7:0]       cmd_byte_q, cmd_byte_d;
  logic             parity_q, parity_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clock_oe_q, clock_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       err_code_q, err_code_d;

  logic clk_s, data_s, clk_fe;

  ps2_line_sync u_sync (
    .clock       (clock),
    .reset       (reset),
    .line_clk_i  (ps2_clock_in),
    .line_data_i (ps2_data_in),
    .clk_s_o     (clk_s),
    .data_s_o    (data_s),
    .clk_fe_o    (clk_fe)
  );

  // State and datapath registers; reset releases both lines and clears pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_byte_q <= 8'h00;
      parity_q   <= 1'b0;
      bit_cnt_q  <= 4'd0;
      cnt_q      <= '0;
      clock_oe_q <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cmd_byte_q <= cmd_byte_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      cnt_q      <= cnt_d;
      clock_oe_q <= clock_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state and registered-output logic. A done/error pulse is issued
  // while still in the working state; the following cycle returns to IDLE,
  // so cmd_ready rises the cycle after the pulse.
  always_comb begin
    state_d    = state_q;
    cmd_byte_d = cmd_byte_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    cnt_d      = cnt_q;
    clock_oe_d = clock_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;

    if (done_q || error_q) begin
      state_d    = ST_IDLE;
      clock_oe_d = 1'b0;
      data_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_byte_d = cmd_data;
            parity_d   = odd_parity(cmd_data);
            cnt_d      = '0;
            clock_oe_d = 1'b1;
            data_oe_d  = 1'b0;
            state_d    = ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            data_oe_d = 1'b1;
            state_d   = ST_REQUEST;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        // Start bit stays driven on data once the clock is released.
        ST_REQUEST: begin
          clock_oe_d = 1'b0;
          cnt_d      = '0;
          bit_cnt_d  = 4'd0;
          state_d    = ST_SEND;
        end

        ST_SEND: begin
          if (clk_fe) begin
            cnt_d     = '0;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q < 4'd8) begin
              data_oe_d = ~cmd_byte_q[bit_cnt_q[2:0]];
            end else if (bit_cnt_q == 4'd8) begin
              data_oe_d = ~parity_q;
            end else begin
              data_oe_d = 1'b0;
              state_d   = ST_ACK;
            end
          end else if (cnt_q == TO_LAST) begin
            clock_oe_d = 1'b0;
            data_oe_d  = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_ACK: begin
          if (clk_fe) begin
            cnt_d = '0;
            if (!data_s) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              error_d    = 1'b1;
              err_code_d = ERR_NOACK;
            end
          end else if (cnt_q == TO_LAST) begin
            clock_oe_d = 1'b0;
            data_oe_d  = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_WAIT_IDLE: begin
          if (clk_s && data_s) begin
            done_d = 1'b1;
          end else if (clk_fe) begin
            cnt_d = '0;
          end else if (cnt_q == TO_LAST) begin
            clock_oe_d = 1'b0;
            data_oe_d  = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_TIMEOUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d    = ST_IDLE;
          clock_oe_d = 1'b0;
          data_oe_d  = 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign ps2_clock_oe = clock_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a PS/2 device model (20-cycle half period)
// that captures the host frame and optionally ACKs.
module tb_ps2_host_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       busy;
  logic       ps2_clock_oe;
  logic       ps2_data_oe;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  logic dev_clk_low;
  logic dev_data_low;
  logic ps2_clock_line;
  logic ps2_data_line;

  assign ps2_clock_line = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data_line  = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (100),
    .TIMEOUT_CYCLES (2000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .busy         (busy),
    .ps2_clock_in (ps2_clock_line),
    .ps2_data_in  (ps2_data_line),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe),
    .done         (done),
    .error        (error),
    .err_code     (err_code)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- monitors ----------------
  int done_total = 0;
  int err_total  = 0;
  int inh_run = 0, last_inh = 0;
  int req_run = 0, last_req = 0;

  always @(negedge clock) begin
    if (done)  done_total <= done_total + 1;
    if (error) err_total  <= err_total + 1;
    if (ps2_clock_oe && !ps2_data_oe) inh_run <= inh_run + 1;
    else begin
      if (inh_run != 0) last_inh <= inh_run;
      inh_run <= 0;
    end
    if (ps2_clock_oe && ps2_data_oe) req_run <= req_run + 1;
    else begin
      if (req_run != 0) last_req <= req_run;
      req_run <= 0;
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [7:0] b);
    int t;
    @(negedge clock);
    cmd_data  = b;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 3000) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!cmd_ready && t < 3000) begin
      @(negedge clock);
      t++;
    end
    check({name, "_ready_wait"}, {31'd0, cmd_ready}, 32'd1);
    repeat (5) @(negedge clock);
  endtask

  // Device model: waits for the host request, samples the start bit, then
  // produces n_fe clock pulses sampling data on each rising edge; the 11th
  // pulse is the ACK clock, with data pulled low when do_ack is set.
  task automatic dev_xfer(input int n_fe, input bit do_ack,
                          output logic [10:0] frame, output bit ok);
    int t;
    ok = 1'b1;
    frame = '0;
    t = 0;
    while (!ps2_clock_oe && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (!ps2_clock_oe) begin ok = 1'b0; return; end
    t = 0;
    while (ps2_clock_oe && t < 1000) begin
      @(negedge clock);
      t++;
    end
    if (ps2_clock_oe) begin ok = 1'b0; return; end
    repeat (10) @(negedge clock);
    frame[0] = ps2_data_line;
    for (int i = 1; i <= n_fe && i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clock);
      dev_clk_low = 1'b0;
      frame[i] = ps2_data_line;
      repeat (20) @(negedge clock);
    end
    if (n_fe >= 11) begin
      dev_data_low = do_ack;
      dev_clk_low  = 1'b1;
      repeat (20) @(negedge clock);
      dev_clk_low  = 1'b0;
      repeat (20) @(negedge clock);
      dev_data_low = 1'b0;
    end
  endtask

  // Full transfer with checks; toggle drives junk requests while busy.
  task automatic run_xfer(input string name, input logic [7:0] data, input bit ack,
                          input logic [10:0] exp_frame, input int exp_done,
                          input int exp_err, input logic [1:0] exp_code, input bit toggle);
    int d0, e0;
    logic [10:0] frame;
    bit ok;
    d0 = done_total;
    e0 = err_total;
    send_cmd(data);
    fork
      dev_xfer(11, ack, frame, ok);
      begin
        if (toggle) begin
          for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            cmd_valid = i[0];
            cmd_data  = 8'hA0 ^ i[7:0];
          end
          cmd_valid = 1'b0;
        end
      end
    join
    wait_ready(name);
    check({name, "_dev_ok"},   {31'd0, ok}, 32'd1);
    check({name, "_frame"},    {21'd0, frame}, {21'd0, exp_frame});
    check({name, "_done_cnt"}, done_total - d0, exp_done);
    check({name, "_err_cnt"},  err_total - e0, exp_err);
    check({name, "_err_code"}, {30'd0, err_code}, {30'd0, exp_code});
    check({name, "_inhibit"},  last_inh, 32'd100);
    check({name, "_request"},  last_req, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] exp_frame;  // {stop, parity, data[7:0], start}
    int          exp_done;
    int          exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [10:0] f1, f2, fr;
    bit ok1, ok2, okr;
    int t, d0, e0, t0, t1, oe_cycles;

    vecs[0] = '{8'hED, 1'b1, 11'b1_1_11101101_0, 1, 0, 2'b00};
    vecs[1] = '{8'hF4, 1'b1, 11'b1_0_11110100_0, 1, 0, 2'b00};
    vecs[2] = '{8'h00, 1'b1, 11'b1_1_00000000_0, 1, 0, 2'b00};
    vecs[3] = '{8'h80, 1'b1, 11'b1_0_10000000_0, 1, 0, 2'b00};
    vecs[4] = '{8'h3C, 1'b0, 11'b1_1_00111100_0, 0, 1, 2'b10};

    // ---- reset ----
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_data     = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_cmd_ready", {31'd0, cmd_ready},    32'd1);
    check("rst_busy",      {31'd0, busy},         32'd0);
    check("rst_clock_oe",  {31'd0, ps2_clock_oe}, 32'd0);
    check("rst_data_oe",   {31'd0, ps2_data_oe},  32'd0);
    check("rst_done",      {31'd0, done},         32'd0);
    check("rst_error",     {31'd0, error},        32'd0);
    check("rst_err_code",  {30'd0, err_code},     32'd0);

    // ---- table-driven transfers ----
    for (int v = 0; v < 5; v++) begin
      run_xfer($sformatf("vec%0d", v), vecs[v].data, vecs[v].ack, vecs[v].exp_frame,
               vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_code, 1'b0);
    end

    // ---- back-to-back 0x01 then 0xFF ----
    d0 = done_total;
    e0 = err_total;
    send_cmd(8'h01);
    cmd_data  = 8'hFF;
    cmd_valid = 1'b1;
    fork
      begin
        dev_xfer(11, 1'b1, f1, ok1);
        dev_xfer(11, 1'b1, f2, ok2);
      end
      begin
        t = 0;
        while (!done && t < 3000) begin
          @(negedge clock);
          t++;
        end
        check("b2b_first_done",     {31'd0, done},      32'd1);
        check("b2b_ready_at_done",  {31'd0, cmd_ready}, 32'd0);
        @(negedge clock);
        check("b2b_ready_after",    {31'd0, cmd_ready}, 32'd1);
        @(negedge clock);
        check("b2b_second_accept",  {31'd0, ps2_clock_oe}, 32'd1);
        check("b2b_busy_again",     {31'd0, busy},      32'd1);
        cmd_valid = 1'b0;
      end
    join
    wait_ready("b2b");
    check("b2b_dev_ok",   {30'd0, ok1, ok2}, 32'd3);
    check("b2b_frame1",   {21'd0, f1}, {21'd0, 11'b1_0_00000001_0});
    check("b2b_frame2",   {21'd0, f2}, {21'd0, 11'b1_1_11111111_0});
    check("b2b_done_cnt", done_total - d0, 32'd2);
    check("b2b_err_cnt",  err_total - e0,  32'd0);

    // ---- timeout: device never clocks ----
    d0 = done_total;
    send_cmd(8'hED);
    t = 0;
    while (ps2_clock_oe && t < 500) begin
      @(negedge clock);
      t++;
    end
    t0 = cyc;
    check("to_released",  {31'd0, ps2_clock_oe}, 32'd0);
    check("to_start_bit", {31'd0, ps2_data_oe},  32'd1);
    t = 0;
    while (!error && t < 3000) begin
      @(negedge clock);
      t++;
    end
    t1 = cyc;
    check("to_error",    {31'd0, error},        32'd1);
    check("to_err_code", {30'd0, err_code},     32'd1);
    check("to_clock_oe", {31'd0, ps2_clock_oe}, 32'd0);
    check("to_data_oe",  {31'd0, ps2_data_oe},  32'd0);
    n_cmp++;
    if ((t1 - t0) < 2000 || (t1 - t0) > 2001) begin
      n_fail++;
      $display("FAIL to_latency: got %0d cycles expected 2000..2001", t1 - t0);
    end
    @(negedge clock);
    check("to_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("to_no_done",     done_total - d0,    32'd0);

    // ---- reset at data bit 4 of 0xA5 ----
    d0 = done_total;
    e0 = err_total;
    send_cmd(8'hA5);
    dev_xfer(5, 1'b0, fr, okr);
    check("rstmid_dev_ok",     {31'd0, okr}, 32'd1);
    check("rstmid_bits",       {26'd0, fr[5:0]}, {26'd0, 6'b001010});
    check("rstmid_bit4_drive", {31'd0, ps2_data_oe}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rstmid_clock_oe", {31'd0, ps2_clock_oe}, 32'd0);
    check("rstmid_data_oe",  {31'd0, ps2_data_oe},  32'd0);
    check("rstmid_ready",    {31'd0, cmd_ready},    32'd1);
    repeat (100) @(negedge clock);
    check("rstmid_no_done",  done_total - d0, 32'd0);
    check("rstmid_no_error", err_total - e0,  32'd0);
    run_xfer("after_rst_f4", 8'hF4, 1'b1, 11'b1_0_11110100_0, 1, 0, 2'b00, 1'b0);

    // ---- requests during a transfer are ignored ----
    run_xfer("ignore_55", 8'h55, 1'b1, 11'b1_1_01010101_0, 1, 0, 2'b00, 1'b1);
    oe_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (ps2_clock_oe) oe_cycles++;
    end
    check("ignore_no_extra_xfer", oe_cycles, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 port. It sends command bytes to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). It is the opposite direction of the existing PS2_Interface receiver: it shares the open-collector ps2_clock/ps2_data lines and sits beside the receiver in the top level. The processor or a small command sequencer drives it through a valid/ready handshake, and it reports ACK or failure per byte.

## Interface
Parameters:
- INHIBIT_CYCLES, 6000: clock-low inhibit time before the request-to-send (120 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum number of cycles without a ps2 clock falling edge during a transfer (15 ms at 50 MHz).

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- cmd_data  in  8  byte to send; sampled only on accept.
- cmd_valid  in  1  request to send cmd_data.
- cmd_ready  out  1  high in IDLE only; accept = cmd_valid & cmd_ready.
- busy  out  1  equals ~cmd_ready; the top level uses it to gate the receiver.
- ps2_clock_in  in  1  raw ps2_clock pad level (asynchronous).
- ps2_data_in  in  1  raw ps2_data pad level (asynchronous).
- ps2_clock_oe  out  1  1 = drive ps2_clock low, 0 = release.
- ps2_data_oe  out  1  1 = drive ps2_data low, 0 = release.
- done  out  1  one-cycle pulse: byte sent and ACK received.
- error  out  1  one-cycle pulse: transfer aborted.
- err_code  out  2  valid with error: 01 = timeout, 10 = no ACK; otherwise holds its last value.

## Operation
- Both raw inputs pass through 2-flop synchronizers. A falling edge (fe) is detected on the synchronized clock.
- On accept, the block latches the byte and computes parity = ~^byte (odd parity).
- FSM states: IDLE, INHIBIT, REQUEST, SEND, ACK, WAIT_IDLE.
- IDLE -> INHIBIT on accept.
- INHIBIT: clock_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then -> REQUEST.
- REQUEST: clock_oe=1, data_oe=1 (start bit) for 1 cycle, then -> SEND.
- SEND: clock_oe=0. Per-bit data_oe updates on each fe, with bit_cnt running 0..9:
  - fe 1–8: data_oe = ~byte[0..7], LSB first.
  - fe 9: data_oe = ~parity.
  - fe 10: data_oe = 0 (stop bit, line released), then -> ACK.
- ACK: on the next fe, sample the synchronized data. If data = 0, -> WAIT_IDLE. If data = 1, pulse error with err_code=10 and -> IDLE.
- WAIT_IDLE: wait until both synchronized lines are 1, then pulse done and -> IDLE.
- Timeout: the counter clears on entry to SEND and on every fe. In SEND, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES releases both oe, pulses error with err_code=01, and -> IDLE.
- cmd_valid outside IDLE is ignored. A changing cmd_data after accept has no effect.
- Reset values: state IDLE, cmd_ready=1, busy=0, both oe=0, done=0, error=0, err_code=00.
- Reset mid-transfer: both lines are released on the next edge, the FSM returns to IDLE, and no done/error pulse is produced.

## Timing
- Accept at edge T:
  - clock_oe=1 from T+1 through T+INHIBIT_CYCLES.
  - REQUEST occupies cycle T+INHIBIT_CYCLES+1.
  - SEND begins at T+INHIBIT_CYCLES+2.
- From a ps2_clock pad falling transition to the data_oe update: 3 cycles (2 sync + 1 edge register). This is well inside the device's roughly 30 µs low phase.
- done and error are mutually exclusive and asserted for exactly one cycle. cmd_ready rises in the cycle after the pulse.
- Minimum back-to-back spacing: a new accept is possible in the cycle cmd_ready=1 after done.
- All outputs are registered. cmd_ready and busy decode directly from the state register.

## Structure
- Package ps2_pkg:
  - FSM state encoding.
  - err_code constants (ERR_TIMEOUT=2'b01, ERR_NOACK=2'b10).
  - Common PS/2 command byte constants (0xED, 0xF4, 0xFF).
- Sub-module ps2_line_sync: 2-flop synchronizer for clock and data plus falling-edge pulse. It is reusable by the receiver.
- Counters:
  - One shared cycle counter, wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES) (20 bits at the defaults).
  - A 4-bit bit_cnt.

## Test plan
Bench: INHIBIT_CYCLES=100, TIMEOUT_CYCLES=2000, with a device model that clocks at a 20-cycle half-period and ACKs.

- Send 0xED -> clock held low 100 cycles, then start bit. The device captures bits 1,0,1,1,0,1,1,1, parity 1 and stop 1; done pulses once and err_code stays 00.
- Send 0x01, then 0xFF back-to-back -> parities 0 then 1. The second accept occurs in the first cycle cmd_ready=1 after done; both bytes are captured correctly.
- Device never clocks after REQUEST -> after 2000 cycles both oe=0, error=1 with err_code=01, cmd_ready=1.
- Device leaves data high at the ACK clock -> error with err_code=10 and no done.
- Assert reset at data bit 4 of 0xA5 -> both oe=0 on the next cycle, no pulse, cmd_ready=1. A following 0xF4 completes normally.
- Toggle cmd_valid with other data during a transfer of 0x55 -> those requests are ignored and only 0x55 appears on the bus.
